word_serializer: RTL and testbench

WORD_SERIALIZER -- requirements
Module: word_serializer

---
 rtl/word_serializer_pkg.sv | 22 ++
 rtl/word_serializer_bit_select.sv | 53 +++++
 rtl/word_serializer.sv | 125 ++++++++++++
 tb/tb_word_serializer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/word_serializer_pkg.sv
// Purpose: shared types and constants for the word_serializer block.
// Contents: FSM state enum, default data width, frame-length helper.
// Optional feature macro: WORD_SERIALIZER_PARITY_EN (adds one even-parity bit per frame).
package word_serializer_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,  // no word held
    ST_SHIFT = 1'b1   // word held, bits being emitted
  } state_t;

  // Number of serial bits per frame for a given data width.
  function automatic int frame_len(input int width);
`ifdef WORD_SERIALIZER_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

endpackage

// File: rtl/word_serializer_bit_select.sv
// Purpose: WIDTH:1 bit selector built from a binary tree of 2:1 muxes.
// Latency: purely combinational, zero cycles.
// Backpressure: none; sel picks data[sel], out-of-range sel reads zero padding.
// Ports: data (word to pick from), sel (bit index), bit_o (selected bit).

module bit_select_mux2 (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic y
);
  assign y = sel ? b : a;
endmodule

module bit_select
  import word_serializer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int SEL_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [SEL_W-1:0] sel,
  output logic             bit_o
);

  // Tree operates on a power-of-two leaf count; unused leaves are zero.
  localparam int N = 1 << SEL_W;

  logic [N-1:0] data_pad;
  assign data_pad = N'(data);

  // Level 0 holds the leaves; each following level halves the node count,
  // steered by the next index bit (LSB nearest the leaves).
  for (genvar l = 0; l <= SEL_W; l++) begin : g_lvl
    localparam int CNT = N >> l;
    logic [CNT-1:0] v;
    if (l == 0) begin : g_leaf
      assign v = data_pad;
    end else begin : g_mux
      for (genvar i = 0; i < CNT; i++) begin : g_node
        bit_select_mux2 u_mux (
          .a   (g_lvl[l-1].v[2*i]),
          .b   (g_lvl[l-1].v[2*i+1]),
          .sel (sel[l-1]),
          .y   (v[i])
        );
      end
    end
  end

  assign bit_o = g_lvl[SEL_W].v[0];

endmodule

// File: rtl/word_serializer.sv
// Purpose: parallel-to-serial converter, one WIDTH-bit word out LSB first as a framed bit stream.
// Latency: first bit valid the cycle after the word is accepted; back-to-back frames with no gap.
// Backpressure: bits advance only on down_valid && down_ready; outputs hold while stalled, up_ready
//   only while idle or on the last-bit transfer.
// Ports: clk; rst (sync, active-low); up_valid/up_data/up_ready (word in);
//   down_valid/down_bit/down_last/down_ready (bit out).
// Optional feature macro: WORD_SERIALIZER_PARITY_EN appends an even-parity bit as the final bit.

module word_serializer
  import word_serializer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  output logic             up_ready,
  output logic             down_valid,
  output logic             down_bit,
  output logic             down_last,
  input  logic             down_ready
);

  localparam int IW        = $clog2(WIDTH + 1);
  localparam int SEL_W     = $clog2(WIDTH);
  localparam int FRAME_LEN = frame_len(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_LEN - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             down_valid_q, down_valid_d;
  logic             down_bit_q, down_bit_d;
  logic             down_last_q, down_last_d;

  logic out_xfer;
  logic last_xfer;
  logic accept;
  logic mux_bit;
  logic sel_bit;

  // Outputs are registered, so the selector looks at the next-cycle word and index.
  bit_select #(
    .WIDTH (WIDTH),
    .SEL_W (SEL_W)
  ) u_bit_select (
    .data  (word_d),
    .sel   (idx_d[SEL_W-1:0]),
    .bit_o (mux_bit)
  );

`ifdef WORD_SERIALIZER_PARITY_EN
  // Index WIDTH is the parity slot, past the last data bit.
  assign sel_bit = (idx_d == IW'(WIDTH)) ? ^word_d : mux_bit;
`else
  assign sel_bit = mux_bit;
`endif

  // Handshakes and next-state.
  always_comb begin
    out_xfer  = down_valid_q && down_ready;
    last_xfer = out_xfer && down_last_q;
    up_ready  = rst && ((state_q == ST_IDLE) || last_xfer);
    accept    = up_valid && up_ready;

    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_SHIFT;
          word_d  = up_data;
          idx_d   = '0;
        end
      end
      ST_SHIFT: begin
        if (last_xfer) begin
          idx_d = '0;
          if (accept) begin
            word_d = up_data;           // next frame starts without a gap
          end else begin
            state_d = ST_IDLE;
            word_d  = '0;
          end
        end else if (out_xfer) begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; bit and last are forced low when idle.
  always_comb begin
    down_valid_d = (state_d == ST_SHIFT);
    down_bit_d   = down_valid_d && sel_bit;
    down_last_d  = down_valid_d && (idx_d == LAST_IDX);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      word_q       <= '0;
      idx_q        <= '0;
      down_valid_q <= 1'b0;
      down_bit_q   <= 1'b0;
      down_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      idx_q        <= idx_d;
      down_valid_q <= down_valid_d;
      down_bit_q   <= down_bit_d;
      down_last_q  <= down_last_d;
    end
  end

  assign down_valid = down_valid_q;
  assign down_bit   = down_bit_q;
  assign down_last  = down_last_q;

endmodule

// File: tb/tb_word_serializer.sv
// Purpose: self-checking bench for word_serializer at WIDTH = 8, with or without parity.
// Latency: expects first bit one cycle after acceptance, frames back to back.
// Backpressure: drives down_ready steady or in a 1,0,0,1 pattern; outputs must hold while stalled.
module tb_word_serializer;

  localparam int W = 8;
`ifdef WORD_SERIALIZER_PARITY_EN
  localparam int FRAME_LEN = 9;
`else
  localparam int FRAME_LEN = 8;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         up_valid;
  logic [W-1:0] up_data;
  logic         up_ready;
  logic         down_valid;
  logic         down_bit;
  logic         down_last;
  logic         down_ready;

  always #5 clk = ~clk;

  word_serializer #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .up_valid   (up_valid),
    .up_data    (up_data),
    .up_ready   (up_ready),
    .down_valid (down_valid),
    .down_bit   (down_bit),
    .down_last  (down_last),
    .down_ready (down_ready)
  );

  // seq lists the expected data bits in transmission order, leftmost first.
  typedef struct {
    logic [7:0] data;
    logic [7:0] seq;
    logic       par;
  } vec_t;

  vec_t       vecs[7];
  logic [1:0] sb[$];   // {bit, last} per expected transfer
  int         total = 0;
  int         bad   = 0;
  logic       stall_mode = 1'b0;
  logic [1:0] ph = 2'd0;
  logic [3:0] pat = 4'b1001;  // ready per cycle: 1,0,0,1
  logic       prev_stall = 1'b0;
  logic       prev_bit   = 1'b0;
  logic       prev_last  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    logic [1:0] e;
    if (!rst) begin
      prev_stall = 1'b0;
      return;
    end
    if (prev_stall)
      check("stall_hold", 32'({down_valid, down_bit, down_last}), 32'({1'b1, prev_bit, prev_last}));
    if (down_valid && down_ready) begin
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("bit_last", 32'({down_bit, down_last}), 32'(e));
      end
    end else if (!down_valid) begin
      check("idle_outs", 32'({down_bit, down_last}), 32'd0);
    end
    prev_stall = down_valid && !down_ready;
    prev_bit   = down_bit;
    prev_last  = down_last;
  endtask

  // One clock: inputs may change just after the edge, outputs sampled on the falling edge.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (stall_mode) begin
      down_ready = pat[ph];
      ph++;
    end
    @(negedge clk);
    monitor();
  endtask

  task automatic push_frame(input logic [7:0] seq, input logic par);
    for (int i = 0; i < 8; i++) sb.push_back({seq[7-i], 1'(i == FRAME_LEN - 1)});
    if (FRAME_LEN > 8) sb.push_back({par, 1'b1});
  endtask

  task automatic wait_accept(input string name);
    int n = 0;
    while (!up_ready && n < 50) begin
      cyc();
      n++;
    end
    check(name, 32'(up_ready), 32'd1);
  endtask

  task automatic send(input vec_t v);
    up_valid = 1'b1;
    up_data  = v.data;
    wait_accept("accept");
    push_frame(v.seq, v.par);
    cyc();
    up_valid = 1'b0;
    up_data  = 8'($urandom);
    check("latency", 32'(down_valid), 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || down_valid) && n < 80) begin
      cyc();
      n++;
    end
    check("drain", 32'(sb.size() == 0 && !down_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0] = '{data: 8'hA5, seq: 8'b10100101, par: 1'b0};
    vecs[1] = '{data: 8'h07, seq: 8'b11100000, par: 1'b1};
    vecs[2] = '{data: 8'h3C, seq: 8'b00111100, par: 1'b0};
    vecs[3] = '{data: 8'hFF, seq: 8'b11111111, par: 1'b0};
    vecs[4] = '{data: 8'h00, seq: 8'b00000000, par: 1'b0};
    vecs[5] = '{data: 8'h01, seq: 8'b10000000, par: 1'b1};
    vecs[6] = '{data: 8'h80, seq: 8'b00000001, par: 1'b1};

    // Reset with a word offered: nothing may be accepted or emitted.
    rst        = 1'b0;
    up_valid   = 1'b1;
    up_data    = 8'hA5;
    down_ready = 1'b1;
    cyc();
    check("rst_down_valid", 32'(down_valid), 32'd0);
    check("rst_down_bit",   32'(down_bit),   32'd0);
    check("rst_down_last",  32'(down_last),  32'd0);
    check("rst_up_ready",   32'(up_ready),   32'd0);
    cyc();
    check("rst_up_ready2",  32'(up_ready),   32'd0);
    rst      = 1'b1;
    up_valid = 1'b0;
    cyc();
    check("idle_up_ready",  32'(up_ready),   32'd1);
    check("idle_valid",     32'(down_valid), 32'd0);

    // Table of single frames with the sink always ready.
    for (int k = 0; k < 7; k++) begin
      send(vecs[k]);
      drain();
    end

    // Sink stalls in a 1,0,0,1 pattern on 8'h3C.
    stall_mode = 1'b1;
    ph         = 2'd0;
    send(vecs[2]);
    drain();
    stall_mode = 1'b0;
    down_ready = 1'b1;
    cyc();

    // Back-to-back 8'hFF then 8'h00 with up_valid held high.
    up_valid = 1'b1;
    up_data  = 8'hFF;
    wait_accept("b2b_accept");
    push_frame(vecs[3].seq, vecs[3].par);
    cyc();
    up_data = 8'h00;
    n = 0;
    while (!up_ready && n < 40) begin
      cyc();
      n++;
    end
    check("b2b_ready_on_last", 32'(down_valid && down_last), 32'd1);
    check("b2b_cycles", n, FRAME_LEN - 1);
    push_frame(vecs[4].seq, vecs[4].par);
    cyc();
    up_valid = 1'b0;
    check("b2b_no_idle", 32'(down_valid), 32'd1);
    drain();

    // Reset while the third bit of 8'hA5 is on the output.
    send(vecs[0]);
    cyc();
    cyc();
    rst = 1'b0;
    sb.delete();
    up_valid = 1'b1;
    up_data  = 8'h5A;
    check("midrst_up_ready", 32'(up_ready), 32'd0);
    cyc();
    check("midrst_down_valid", 32'(down_valid), 32'd0);
    check("midrst_down_bit",   32'(down_bit),   32'd0);
    check("midrst_down_last",  32'(down_last),  32'd0);
    check("midrst_up_ready2",  32'(up_ready),   32'd0);
    cyc();
    rst      = 1'b1;
    up_valid = 1'b0;
    cyc();
    check("post_rst_idle", 32'(down_valid), 32'd0);
    send(vecs[5]);
    drain();

    // Offered data changing while busy must be ignored.
    send(vecs[2]);
    up_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      up_data = 8'($urandom);
      check("busy_up_ready", 32'(up_ready), 32'd0);
      cyc();
    end
    up_valid = 1'b0;
    drain();

    cyc();
    check("final_idle", 32'(down_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
